// File: rtl/pipe_pkg.sv
// Shared definitions for the core's pipeline boundary registers: per-boundary
// control words, their side-effect-free kill values and a control-width helper.
package pipe_pkg;

  typedef enum logic [1:0] {
    BND_FD,
    BND_DE,
    BND_EM,
    BND_MW
  } pipe_bnd_e;

  typedef enum logic [1:0] {
    ENTRY_EMPTY,
    ENTRY_ONE,
    ENTRY_FULL
  } entry_state_e;

  typedef struct packed {
    logic pred_taken;
    logic instr_fault;
  } fd_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [2:0] alu_control;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } de_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic [4:0] rd;
  } em_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic [4:0] rd;
  } mw_ctrl_t;

  localparam fd_ctrl_t FD_CTRL_KILL = '{pred_taken: 1'b0, instr_fault: 1'b0};

  localparam de_ctrl_t DE_CTRL_KILL = '{
    reg_write:   1'b0,
    result_src:  2'b00,
    mem_write:   1'b0,
    jump:        1'b0,
    branch:      1'b0,
    alu_control: 3'b000,
    rs1:         5'd0,
    rs2:         5'd0,
    rd:          5'd0
  };

  localparam em_ctrl_t EM_CTRL_KILL = '{
    reg_write:  1'b0,
    result_src: 2'b00,
    mem_write:  1'b0,
    rd:         5'd0
  };

  localparam mw_ctrl_t MW_CTRL_KILL = '{
    reg_write:  1'b0,
    result_src: 2'b00,
    rd:         5'd0
  };

  function automatic int unsigned ctrl_width(input pipe_bnd_e bnd);
    case (bnd)
      BND_FD:  return $bits(fd_ctrl_t);
      BND_DE:  return $bits(de_ctrl_t);
      BND_EM:  return $bits(em_ctrl_t);
      BND_MW:  return $bits(mw_ctrl_t);
      default: return $bits(de_ctrl_t);
    endcase
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid bit, control word and payload, with load, drop
// (valid clear only), kill (force safe control) and asynchronous clear.
module pipe_slot #(
  parameter int unsigned       DATA_W    = 160,
  parameter int unsigned       CTRL_W    = 24,
  parameter logic [CTRL_W-1:0] CTRL_KILL = '0,
  parameter bit                ZERO_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              drop_i,
  input  logic              kill_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic [DATA_W-1:0] data_q,  data_d;

  // Kill outranks load so a beat arriving with a flush is swallowed.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (kill_i) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_KILL;
      if (ZERO_DATA) begin
        data_d = '0;
      end
    end else if (load_i) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_i;
      data_d  = data_i;
    end else if (drop_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_KILL;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline boundary register with optional skid entry, flush-to-safe
// control, and saturating stall/bubble performance counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W    = 160,
  parameter int unsigned       CTRL_W    = ctrl_width(BND_DE),
  parameter logic [CTRL_W-1:0] CTRL_KILL = '0,
  parameter bit                SKID      = 1'b1,
  parameter bit                ZERO_DATA = 1'b1,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              xfer_in;
  logic              main_load, main_drop, main_valid;
  logic [CTRL_W-1:0] main_ctrl, main_ctrl_in;
  logic [DATA_W-1:0] main_data, main_data_in;
  entry_state_e      occ;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  assign xfer_in = in_valid && in_ready;

  pipe_slot #(
    .DATA_W    (DATA_W),
    .CTRL_W    (CTRL_W),
    .CTRL_KILL (CTRL_KILL),
    .ZERO_DATA (ZERO_DATA)
  ) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (main_load),
    .drop_i  (main_drop),
    .kill_i  (flush),
    .ctrl_i  (main_ctrl_in),
    .data_i  (main_data_in),
    .valid_o (main_valid),
    .ctrl_o  (main_ctrl),
    .data_o  (main_data)
  );

  if (SKID) begin : gen_skid
    logic              skid_load, skid_drop, skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    pipe_slot #(
      .DATA_W    (DATA_W),
      .CTRL_W    (CTRL_W),
      .CTRL_KILL (CTRL_KILL),
      .ZERO_DATA (ZERO_DATA)
    ) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (skid_load),
      .drop_i  (skid_drop),
      .kill_i  (flush),
      .ctrl_i  (in_ctrl),
      .data_i  (in_data),
      .valid_o (skid_valid),
      .ctrl_o  (skid_ctrl),
      .data_o  (skid_data)
    );

    // Ready depends only on stored state, cutting the out_ready->in_ready path.
    assign in_ready = !skid_valid;

    always_comb begin
      main_load    = 1'b0;
      main_drop    = 1'b0;
      skid_load    = 1'b0;
      skid_drop    = 1'b0;
      main_ctrl_in = in_ctrl;
      main_data_in = in_data;
      if (skid_valid) begin
        occ = ENTRY_FULL;
      end else if (main_valid) begin
        occ = ENTRY_ONE;
      end else begin
        occ = ENTRY_EMPTY;
      end
      case (occ)
        ENTRY_EMPTY: main_load = xfer_in;
        ENTRY_ONE: begin
          if (out_ready) begin
            main_load = xfer_in;
            main_drop = !xfer_in;
          end else begin
            skid_load = xfer_in;
          end
        end
        ENTRY_FULL: begin
          // Older skid beat advances first; any new beat refills the skid.
          if (out_ready) begin
            main_load    = 1'b1;
            main_ctrl_in = skid_ctrl;
            main_data_in = skid_data;
            skid_load    = xfer_in;
            skid_drop    = !xfer_in;
          end
        end
        default: ;
      endcase
    end
  end else begin : gen_noskid
    assign in_ready = !main_valid || out_ready;

    always_comb begin
      main_load    = 1'b0;
      main_drop    = 1'b0;
      main_ctrl_in = in_ctrl;
      main_data_in = in_data;
      occ          = main_valid ? ENTRY_ONE : ENTRY_EMPTY;
      case (occ)
        ENTRY_EMPTY: main_load = xfer_in;
        ENTRY_ONE: begin
          main_load = xfer_in;
          main_drop = out_ready && !xfer_in;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (main_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (!main_valid && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign out_valid  = main_valid;
  assign out_ctrl   = main_ctrl;
  assign out_data   = main_data;
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid, no-skid and narrow-counter instances.
module tb_pipe_stage_reg;

  localparam int unsigned       DW   = 32;
  localparam int unsigned       CW   = 24;
  localparam logic [CW-1:0]     KILL = 24'h5A0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // skid instance
  logic          d_in_valid, d_in_ready, d_flush, d_out_valid, d_out_ready;
  logic [DW-1:0] d_in_data, d_out_data;
  logic [CW-1:0] d_in_ctrl, d_out_ctrl;
  logic [15:0]   d_stall, d_bubble;
  // no-skid instance
  logic          n_in_valid, n_in_ready, n_flush, n_out_valid, n_out_ready;
  logic [DW-1:0] n_in_data, n_out_data;
  logic [CW-1:0] n_in_ctrl, n_out_ctrl;
  logic [15:0]   n_stall, n_bubble;
  // narrow-counter instance
  logic          s_in_valid, s_in_ready, s_flush, s_out_valid, s_out_ready;
  logic [DW-1:0] s_in_data, s_out_data;
  logic [CW-1:0] s_in_ctrl, s_out_ctrl;
  logic [3:0]    s_stall, s_bubble;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_KILL(KILL), .SKID(1'b1),
                   .ZERO_DATA(1'b1), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_data(d_in_data), .in_ctrl(d_in_ctrl), .flush(d_flush),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data),
    .out_ctrl(d_out_ctrl), .stall_cnt(d_stall), .bubble_cnt(d_bubble));

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_KILL(KILL), .SKID(1'b0),
                   .ZERO_DATA(1'b1), .CNT_W(16)) u_ns (
    .clk(clk), .rst_n(rst_n), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .in_data(n_in_data), .in_ctrl(n_in_ctrl), .flush(n_flush),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
    .out_ctrl(n_out_ctrl), .stall_cnt(n_stall), .bubble_cnt(n_bubble));

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_KILL(KILL), .SKID(1'b1),
                   .ZERO_DATA(1'b1), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .in_ctrl(s_in_ctrl), .flush(s_flush),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .out_ctrl(s_out_ctrl), .stall_cnt(s_stall), .bubble_cnt(s_bubble));

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] ctrl_of(input logic [DW-1:0] d);
    return {8'hC3, d[15:0]};
  endfunction

  task automatic d_drive(input logic v, input logic [DW-1:0] d);
    d_in_valid = v;
    d_in_data  = d;
    d_in_ctrl  = ctrl_of(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          exp_ready;
    int unsigned   next_tx, next_rx;

    rst_n = 1'b0;
    d_drive(1'b1, 32'h1);
    d_flush = 1'b0; d_out_ready = 1'b1;
    n_in_valid = 1'b0; n_in_data = '0; n_in_ctrl = '0; n_flush = 1'b0; n_out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_data = '0; s_in_ctrl = '0; s_flush = 1'b0; s_out_ready = 1'b1;

    // reset held with a beat offered
    repeat (3) begin
      @(negedge clk);
      check("rst_out_valid", 64'(d_out_valid), 64'(0));
      check("rst_out_ctrl",  64'(d_out_ctrl),  64'(KILL));
      check("rst_out_data",  64'(d_out_data),  64'(0));
      check("rst_in_ready",  64'(d_in_ready),  64'(1));
      check("rst_stall",     64'(d_stall),     64'(0));
      check("rst_bubble",    64'(d_bubble),    64'(0));
    end
    rst_n = 1'b1;

    // streaming 0x1..0x8
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("strm_valid", 64'(d_out_valid), 64'(1));
      check("strm_data",  64'(d_out_data),  64'(i));
      check("strm_ctrl",  64'(d_out_ctrl),  64'(ctrl_of(DW'(i))));
      if (i < 8) d_drive(1'b1, DW'(i + 1));
      else       d_drive(1'b0, '0);
    end
    check("strm_stall",   64'(d_stall),  64'(0));
    check("strm_bubble",  64'(d_bubble), 64'(1));
    check("sat_bubble_8", 64'(s_bubble), 64'(8));
    @(negedge clk);
    check("drain_valid", 64'(d_out_valid), 64'(0));

    // backpressure with skid
    d_out_ready = 1'b0;
    d_drive(1'b1, 32'hA);
    @(negedge clk);
    check("bp_a_data",    64'(d_out_data), 64'(32'hA));
    check("bp_a_inready", 64'(d_in_ready), 64'(1));
    d_drive(1'b1, 32'hB);
    @(negedge clk);
    check("bp_hold_a",    64'(d_out_data), 64'(32'hA));
    check("bp_inready_0", 64'(d_in_ready), 64'(0));
    d_drive(1'b1, 32'hC);
    repeat (3) @(negedge clk);
    check("bp_still_a",   64'(d_out_data), 64'(32'hA));
    check("bp_still_ctl", 64'(d_out_ctrl), 64'(ctrl_of(32'hA)));
    check("bp_inready_h", 64'(d_in_ready), 64'(0));
    check("bp_stall_4",   64'(d_stall),    64'(4));
    d_out_ready = 1'b1;
    @(negedge clk);
    check("bp_b_valid",   64'(d_out_valid), 64'(1));
    check("bp_b_data",    64'(d_out_data),  64'(32'hB));
    check("bp_inready_1", 64'(d_in_ready),  64'(1));
    @(negedge clk);
    check("bp_c_data",    64'(d_out_data),  64'(32'hC));
    d_drive(1'b0, '0);
    @(negedge clk);
    check("bp_empty",     64'(d_out_valid), 64'(0));
    check("bp_stall_end", 64'(d_stall),     64'(4));
    check("bp_bubble",    64'(d_bubble),    64'(2));

    // flush while FULL with 0xD offered
    d_out_ready = 1'b0;
    d_drive(1'b1, 32'h21);
    @(negedge clk);
    d_drive(1'b1, 32'h22);
    @(negedge clk);
    check("fl_full_rdy",  64'(d_in_ready),  64'(0));
    d_drive(1'b1, 32'hD);
    d_flush = 1'b1;
    @(negedge clk);
    check("fl_valid",     64'(d_out_valid), 64'(0));
    check("fl_ctrl",      64'(d_out_ctrl),  64'(KILL));
    check("fl_data",      64'(d_out_data),  64'(0));
    check("fl_inready",   64'(d_in_ready),  64'(1));
    d_flush = 1'b0;
    d_out_ready = 1'b1;
    d_drive(1'b1, 32'hE);
    @(negedge clk);
    check("fl_e_valid",   64'(d_out_valid), 64'(1));
    check("fl_e_data",    64'(d_out_data),  64'(32'hE));
    check("fl_e_ctrl",    64'(d_out_ctrl),  64'(ctrl_of(32'hE)));
    d_drive(1'b0, '0);
    @(negedge clk);
    check("fl_e_gone",    64'(d_out_valid), 64'(0));

    // flush in ONE swallows the beat accepted the same cycle
    d_out_ready = 1'b0;
    d_drive(1'b1, 32'h31);
    @(negedge clk);
    check("f1_data",      64'(d_out_data),  64'(32'h31));
    d_drive(1'b1, 32'h33);
    d_flush = 1'b1;
    check("f1_consumed",  64'(d_in_ready),  64'(1));
    @(negedge clk);
    check("f1_valid",     64'(d_out_valid), 64'(0));
    d_flush = 1'b0;
    d_drive(1'b0, '0);
    d_out_ready = 1'b1;
    @(negedge clk);
    check("f1_no_ghost",  64'(d_out_valid), 64'(0));
    check("f1_stall",     64'(d_stall),     64'(7));
    check("f1_bubble",    64'(d_bubble),    64'(6));

    // narrow counters saturate
    check("sat_bubble",   64'(s_bubble),    64'(15));
    check("sat_stall",    64'(s_stall),     64'(0));

    // no-skid stage with out_ready toggling
    m_valid = 1'b0;
    m_data  = '0;
    next_tx = 1;
    next_rx = 1;
    for (int c = 0; c < 12; c++) begin
      n_out_ready = c[0];
      n_in_valid  = 1'b1;
      n_in_data   = DW'(next_tx);
      n_in_ctrl   = ctrl_of(DW'(next_tx));
      #1;
      exp_ready = !m_valid || n_out_ready;
      check("ns_in_ready",  64'(n_in_ready),  64'(exp_ready));
      check("ns_out_valid", 64'(n_out_valid), 64'(m_valid));
      if (m_valid) begin
        check("ns_data", 64'(n_out_data), 64'(m_data));
      end
      if (m_valid && n_out_ready) begin
        check("ns_order", 64'(n_out_data), 64'(next_rx));
        next_rx++;
      end
      if (exp_ready) begin
        m_data = DW'(next_tx);
        next_tx++;
      end
      m_valid = exp_ready || (m_valid && !n_out_ready);
      @(negedge clk);
    end
    n_in_valid  = 1'b0;
    n_out_ready = 1'b1;
    #1;
    check("ns_last_data", 64'(n_out_data), 64'(7));
    @(negedge clk);
    check("ns_drained",   64'(n_out_valid), 64'(0));

    // reset asserted mid-stream acts without a clock edge
    d_out_ready = 1'b0;
    d_drive(1'b1, 32'h41);
    @(negedge clk);
    check("ar_loaded",    64'(d_out_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid",     64'(d_out_valid), 64'(0));
    check("ar_ctrl",      64'(d_out_ctrl),  64'(KILL));
    check("ar_data",      64'(d_out_data),  64'(0));
    check("ar_inready",   64'(d_in_ready),  64'(1));
    check("ar_stall",     64'(d_stall),     64'(0));
    check("ar_bubble",    64'(d_bubble),    64'(0));
    @(negedge clk);
    d_drive(1'b0, '0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
